data_sampling_mv: RTL and testbench

//  Parametrised mid-bit sampler and majority voter for the UART RX datapath.

---
 rtl/data_sampling_mv.sv | 101 ++++++++++
 tb/tb_data_sampling_mv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sampling_mv.sv
// Mid-bit majority-vote sampler for the UART RX datapath.
// Optional macro DATA_SAMP_SYNC_EN puts a 2-flop synchronizer (reset to 1) in front of RX_IN.
module data_sampling_mv #(
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned SAMPLES        = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      dat_samp_en,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      sampled_bit,
  output logic                      sample_valid,
  output logic                      noise_flag
);

  localparam int unsigned CW   = $clog2(SAMPLES + 1);
  localparam int unsigned HALF = SAMPLES >> 1;

  logic rx;

`ifdef DATA_SAMP_SYNC_EN
  logic [1:0] sync;

  // Idle-high synchronizer so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync <= 2'b11;
    else      sync <= {sync[0], RX_IN};
  end

  assign rx = sync[1];
`else
  assign rx = RX_IN;
`endif

  logic [PRESCALE_WIDTH-1:0] mid, w_first, w_last;
  logic                      in_win, is_first, is_last;

  assign mid      = Prescale >> 1;
  assign w_first  = mid - PRESCALE_WIDTH'(HALF);
  assign w_last   = mid + PRESCALE_WIDTH'(HALF);
  assign in_win   = (edge_cnt >= w_first) && (edge_cnt <= w_last);
  assign is_first = (edge_cnt == w_first);
  assign is_last  = (edge_cnt == w_last);

  logic [CW-1:0] ones, cnt, ones_n, cnt_n;
  logic [CW-1:0] ones_base, cnt_base, total;
  logic          bit_n, noise_n, valid_n;

  // The first window tick restarts the accumulator, dropping any stale partial.
  assign ones_base = is_first ? '0 : ones;
  assign cnt_base  = is_first ? '0 : cnt;
  assign total     = ones_base + CW'(rx);

  always_comb begin
    ones_n  = ones;
    cnt_n   = cnt;
    bit_n   = sampled_bit;
    noise_n = noise_flag;
    valid_n = 1'b0;
    if (!dat_samp_en) begin
      ones_n = '0;
      cnt_n  = '0;
    end else if (in_win) begin
      if (is_last) begin
        ones_n = '0;
        cnt_n  = '0;
        if (cnt_base == CW'(SAMPLES - 1)) begin
          valid_n = 1'b1;
          bit_n   = (total > CW'(HALF));
          noise_n = (total != '0) && (total != CW'(SAMPLES));
        end
      end else if (cnt_base < CW'(SAMPLES)) begin
        // Count saturates so repeated ticks can never wrap into a false completion.
        cnt_n  = cnt_base + CW'(1);
        ones_n = total;
      end else begin
        cnt_n  = cnt_base;
        ones_n = ones_base;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ones         <= '0;
      cnt          <= '0;
      sampled_bit  <= 1'b1;
      noise_flag   <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      ones         <= ones_n;
      cnt          <= cnt_n;
      sampled_bit  <= bit_n;
      noise_flag   <= noise_n;
      sample_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_data_sampling_mv.sv
// Scoreboard bench for data_sampling_mv: four instances (SAMPLES = 1,3,5,7) share one stimulus stream.
module tb_data_sampling_mv;

  localparam int NDUT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rx_in;
  logic            en;
  logic [5:0]      prescale;
  logic [5:0]      edge_cnt;
  logic [NDUT-1:0] sb, sv, nf;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_sampling_mv #(.PRESCALE_WIDTH(6), .SAMPLES(2*g+1)) u_dut (
      .CLK          (clk),
      .RST          (rst_n),
      .RX_IN        (rx_in),
      .dat_samp_en  (en),
      .Prescale     (prescale),
      .edge_cnt     (edge_cnt),
      .sampled_bit  (sb[g]),
      .sample_valid (sv[g]),
      .noise_flag   (nf[g])
    );
  end

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  bit         win_q [NDUT][$];
  int         exp_q [NDUT][$];
  logic [1:0] cur   [NDUT];
  logic       d1, d2;

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input int g, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s dut%0d (SAMPLES=%0d) cyc=%0d: got %0d required %0d", name, g, 2*g+1, cyc, got, want);
    end
  endfunction

  // Monitor: pops expected {bit,noise} on each strobe, else checks outputs hold.
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (sv[g]) begin
        if (exp_q[g].size() == 0) begin
          check("spurious_strobe", g, 1, 0);
        end else begin
          int e;
          e = exp_q[g].pop_front();
          check("strobe_time", g, cyc, e >> 2);
          check("vote", g, int'({sb[g], nf[g]}), e & 3);
          cur[g] = 2'(e & 3);
        end
      end else begin
        if (exp_q[g].size() != 0 && (exp_q[g][0] >> 2) <= cyc)
          check("missing_strobe", g, 0, 1);
        check("hold", g, int'({sb[g], nf[g]}), int'(cur[g]));
      end
    end
  end

  // Drive one oversample tick and advance the reference model.
  task automatic step(input logic rx, input logic e_en, input int e);
    logic eff;
    int   mid, wf, wl, s, ones;
    rx_in    = rx;
    en       = e_en;
    edge_cnt = 6'(e);
    eff      = rx;
`ifdef DATA_SAMP_SYNC_EN
    eff = d2;
    d2  = d1;
    d1  = rx;
`endif
    mid = int'(prescale) / 2;
    for (int g = 0; g < NDUT; g++) begin
      s  = 2*g + 1;
      wf = mid - g;
      wl = mid + g;
      if (!e_en) begin
        win_q[g].delete();
      end else if (e >= wf && e <= wl) begin
        if (e == wf) win_q[g].delete();
        win_q[g].push_back(eff);
        if (e == wl) begin
          if (win_q[g].size() == s) begin
            ones = 0;
            for (int i = 0; i < win_q[g].size(); i++) ones += int'(win_q[g][i]);
            exp_q[g].push_back((cyc + 1) * 4 + (ones > g ? 2 : 0) + ((ones != 0 && ones != s) ? 1 : 0));
          end
          win_q[g].delete();
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      win_q[g].delete();
      exp_q[g].delete();
      cur[g] = 2'b10;
    end
    d1 = 1'b1;
    d2 = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_p(input int p);
    step(1'b1, 1'b0, 0);
    prescale = 6'(p);
    step(1'b1, 1'b0, 0);
  endtask

  task automatic run_bit(input int p, input logic [63:0] pat, input int drop_at, input int rst_at);
    for (int e = 0; e < p; e++) begin
      if (e == rst_at) do_reset();
      step(pat[e], !(drop_at >= 0 && e >= drop_at), e);
    end
  endtask

  initial begin
    logic [63:0] pat;
    int          p, d0, dl, rep, skp, rst_at, e;
    bit          repeated, did_rst, v;

    rst_n    = 1'b0;
    rx_in    = 1'b1;
    en       = 1'b0;
    prescale = 6'd16;
    edge_cnt = '0;
    d1       = 1'b1;
    d2       = 1'b1;
    for (int g = 0; g < NDUT; g++) cur[g] = 2'b10;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Steady low line: clean 0 vote.
    set_p(16);
    run_bit(16, 64'h0, -1, -1);
    // High line with one low sample near the start of the window: 1 with noise.
    pat = ~64'h0;
    pat[7] = 1'b0;
    run_bit(16, pat, -1, -1);
    // Enable dropped mid-window: no strobe, outputs hold.
    run_bit(16, 64'h0, 8, -1);
    // Reset inside the window with a low line.
    run_bit(16, 64'h0, -1, 8);
    // Back-to-back bits at the largest oversampling ratio.
    set_p(32);
    run_bit(32, 64'h0, -1, -1);
    run_bit(32, ~64'h0, -1, -1);
    run_bit(32, 64'h0, -1, -1);
    // Line rises one tick before the SAMPLES=3 window.
    set_p(16);
    pat = 64'h0;
    for (int i = 6; i < 64; i++) pat[i] = 1'b1;
    run_bit(16, pat, -1, -1);

    // Randomized bits with noise, enable dropouts, repeated/skipped ticks and resets.
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 7) == 0) set_p(14 + 2 * int'($urandom_range(0, 9)));
      p = int'(prescale);
      v = 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) pat[i] = v ^ ($urandom_range(0, 5) == 0);
      d0     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -10;
      dl     = int'($urandom_range(1, 3));
      rep    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1;
      skp    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1;
      rst_at = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 31)) : -1;
      e = 0;
      repeated = 1'b0;
      did_rst  = 1'b0;
      while (e < p) begin
        if (e == rst_at && !did_rst) begin
          do_reset();
          did_rst = 1'b1;
        end
        step(pat[e], !(e >= d0 && e < d0 + dl), e);
        if (e == rep && !repeated) repeated = 1'b1;
        else if (e == skp)         e += 2;
        else                       e++;
      end
    end

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);
    for (int g = 0; g < NDUT; g++) check("drain", g, exp_q[g].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
